// File: rtl/eq_serial_tx_amisha.sv
// Word-pair to bit-serial transmitter for the equality link; optional all-equal monitor via EQ_SERIAL_TX_MON_EN.
// Latency: beat 0 appears one edge after load accept. Backpressure: ser_ready low freezes the beat; load_ready only in IDLE or on the final beat.
module eq_serial_tx_amisha #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic             load_valid_amisha,
  output logic             load_ready_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             ser_valid_amisha,
  input  logic             ser_ready_amisha,
  output logic             i0_amisha,
  output logic             i1_amisha,
  output logic             last_amisha,
  output logic             busy_amisha
`ifdef EQ_SERIAL_TX_MON_EN
  ,
  output logic             all_eq_amisha,
  output logic             all_eq_valid_amisha
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    count;
  logic             beat_acc;
  logic             final_acc;
  logic             load_acc;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Shift toward the output end so the next bit to send is always at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign beat_acc          = ser_valid_amisha & ser_ready_amisha;
  assign final_acc         = beat_acc & last_amisha;
  assign load_ready_amisha = (state == IDLE) | final_acc;
  assign load_acc          = load_valid_amisha & load_ready_amisha;

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state            <= IDLE;
      sh_a             <= '0;
      sh_b             <= '0;
      count            <= '0;
      ser_valid_amisha <= 1'b0;
      i0_amisha        <= 1'b0;
      i1_amisha        <= 1'b0;
      last_amisha      <= 1'b0;
      busy_amisha      <= 1'b0;
    end else if (load_acc) begin
      state            <= SHIFT;
      busy_amisha      <= 1'b1;
      ser_valid_amisha <= 1'b1;
      i0_amisha        <= head_bit(a_amisha);
      i1_amisha        <= head_bit(b_amisha);
      sh_a             <= advance(a_amisha);
      sh_b             <= advance(b_amisha);
      count            <= '0;
      last_amisha      <= 1'b0;
    end else if (beat_acc) begin
      if (last_amisha) begin
        // Counter parks at WIDTH-1 until the next load clears it.
        state            <= IDLE;
        busy_amisha      <= 1'b0;
        ser_valid_amisha <= 1'b0;
        last_amisha      <= 1'b0;
      end else begin
        i0_amisha   <= head_bit(sh_a);
        i1_amisha   <= head_bit(sh_b);
        sh_a        <= advance(sh_a);
        sh_b        <= advance(sh_b);
        count       <= count + CW'(1);
        last_amisha <= (count == CW'(WIDTH - 2));
      end
    end
  end

`ifdef EQ_SERIAL_TX_MON_EN
  logic eq_run;
  logic eq_next;

  assign eq_next = eq_run & ~(i0_amisha ^ i1_amisha);

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      eq_run              <= 1'b0;
      all_eq_amisha       <= 1'b0;
      all_eq_valid_amisha <= 1'b0;
    end else begin
      all_eq_valid_amisha <= final_acc;
      if (final_acc) all_eq_amisha <= eq_next;
      if (load_acc) eq_run <= 1'b1;
      else if (beat_acc) eq_run <= eq_next;
    end
  end
`endif

endmodule

// File: tb/tb_eq_serial_tx_amisha.sv
// Bench for eq_serial_tx_amisha: LSB-first and MSB-first instances driven in lockstep against a beat-queue reference.
module tb_eq_serial_tx_amisha;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ser_ready;

  logic lr0, sv0, i00, i10, last0, busy0;
  logic lr1, sv1, i01, i11, last1, busy1;
`ifdef EQ_SERIAL_TX_MON_EN
  logic eq0, eqv0, eq1, eqv1;
`endif

  eq_serial_tx_amisha #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk_amisha(clk), .reset_n_amisha(rst_n),
    .load_valid_amisha(load_valid), .load_ready_amisha(lr0),
    .a_amisha(a), .b_amisha(b),
    .ser_valid_amisha(sv0), .ser_ready_amisha(ser_ready),
    .i0_amisha(i00), .i1_amisha(i10), .last_amisha(last0), .busy_amisha(busy0)
`ifdef EQ_SERIAL_TX_MON_EN
    , .all_eq_amisha(eq0), .all_eq_valid_amisha(eqv0)
`endif
  );

  eq_serial_tx_amisha #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk_amisha(clk), .reset_n_amisha(rst_n),
    .load_valid_amisha(load_valid), .load_ready_amisha(lr1),
    .a_amisha(a), .b_amisha(b),
    .ser_valid_amisha(sv1), .ser_ready_amisha(ser_ready),
    .i0_amisha(i01), .i1_amisha(i11), .last_amisha(last1), .busy_amisha(busy1)
`ifdef EQ_SERIAL_TX_MON_EN
    , .all_eq_amisha(eq1), .all_eq_valid_amisha(eqv1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: each queue entry is one pending beat {i0, i1, last}.
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic       qe[$];
  logic       exp_eq  = 1'b0;
  logic       exp_eqv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (q0.size() == 0) return 1'b1;
    return ser_ready & q0[0][0];
  endfunction

  task automatic check_outputs();
    logic v;
    v = (q0.size() != 0);
    chk("lsb_valid", 32'(sv0), 32'(v));
    chk("lsb_busy", 32'(busy0), 32'(v));
    chk("lsb_ready", 32'(lr0), 32'(exp_ready()));
    chk("lsb_last", 32'(last0), v ? 32'(q0[0][0]) : 32'd0);
    chk("msb_valid", 32'(sv1), 32'(v));
    chk("msb_ready", 32'(lr1), 32'(exp_ready()));
    chk("msb_last", 32'(last1), v ? 32'(q1[0][0]) : 32'd0);
    if (v) begin
      chk("lsb_bits", 32'({i00, i10}), 32'(q0[0][2:1]));
      chk("msb_bits", 32'({i01, i11}), 32'(q1[0][2:1]));
    end
`ifdef EQ_SERIAL_TX_MON_EN
    chk("lsb_all_eq_vld", 32'(eqv0), 32'(exp_eqv));
    chk("lsb_all_eq", 32'(eq0), 32'(exp_eq));
    chk("msb_all_eq_vld", 32'(eqv1), 32'(exp_eqv));
    chk("msb_all_eq", 32'(eq1), 32'(exp_eq));
`endif
  endtask

  task automatic model_edge();
    logic rdy, acc, fin;
    int   idx;
    rdy = exp_ready();
    acc = (q0.size() != 0) && ser_ready;
    fin = acc && q0[0][0];
    exp_eqv = fin;
    if (fin) exp_eq = qe.pop_front();
    if (acc) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (load_valid && rdy) begin
      for (int k = 0; k < W; k++) begin
        idx = W - 1 - k;
        q0.push_back({a[k], b[k], k == W - 1});
        q1.push_back({a[idx], b[idx], k == W - 1});
      end
      qe.push_back(a == b);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    qe.delete();
    exp_eq  = 1'b0;
    exp_eqv = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   f_lsb;
    logic [1:0]   f_msb;
    logic         eq;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bn, lp0, lp1;
    tbl[0] = '{8'hA5, 8'hA5, 2'b11, 2'b11, 1'b1};
    tbl[1] = '{8'hA5, 8'hA4, 2'b10, 2'b11, 1'b0};
    tbl[2] = '{8'h0F, 8'hF0, 2'b10, 2'b01, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 2'b11, 2'b11, 1'b1};
    tbl[4] = '{8'h00, 8'h80, 2'b00, 2'b01, 1'b0};
    tbl[5] = '{8'h5A, 8'h5A, 2'b00, 2'b00, 1'b1};

    rst_n = 1'b0; load_valid = 1'b0; a = '0; b = '0; ser_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(sv0), 32'd0);
    chk("rst_ready", 32'(lr0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_bits", 32'({i00, i10, last0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();

    // Directed table: first-beat bit order for both orders, transfer length, equality result.
    for (int t = 0; t < 6; t++) begin
      load_valid = 1'b1; a = tbl[t].a; b = tbl[t].b; ser_ready = 1'b1;
      step();
      load_valid = 1'b0;
      chk("tbl_first_lsb", 32'({i00, i10}), 32'(tbl[t].f_lsb));
      chk("tbl_first_msb", 32'({i01, i11}), 32'(tbl[t].f_msb));
      n = 0;
      while (busy0 && n < 20) begin
        step();
        n++;
      end
      chk("tbl_xfer_len", 32'(n), 32'd8);
`ifdef EQ_SERIAL_TX_MON_EN
      chk("tbl_all_eq", 32'(eq0), 32'(tbl[t].eq));
      chk("tbl_all_eq_vld", 32'(eqv0), 32'd1);
`endif
      step();
    end

    // Stall on beat 3 for four cycles.
    load_valid = 1'b1; a = 8'hA5; b = 8'h3C; ser_ready = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (3) step();
    ser_ready = 1'b0;
    repeat (4) begin
      step();
      chk("stall_hold", 32'({i00, i10, last0}), 32'b010);
    end
    ser_ready = 1'b1;
    n = 7;
    while (busy0 && n < 30) begin
      step();
      n++;
    end
    chk("stall_len", 32'(n), 32'd12);
    step();

    // Back-to-back transfers with the second load on the final beat.
    load_valid = 1'b1; a = 8'hA5; b = 8'hA5;
    step();
    load_valid = 1'b0;
    bn = 0; lp0 = 0; lp1 = 0; n = 0;
    while (sv0 && n < 30) begin
      bn++;
      if (last0) begin
        if (lp0 == 0) lp0 = bn;
        else lp1 = bn;
      end
      if (last0 && bn == 8) begin
        load_valid = 1'b1; a = 8'h0F; b = 8'hF0;
      end else begin
        load_valid = 1'b0;
      end
      step();
      n++;
    end
    chk("b2b_beats", 32'(bn), 32'd16);
    chk("b2b_last1", 32'(lp0), 32'd8);
    chk("b2b_last2", 32'(lp1), 32'd16);
    step();

    // Reset during beat 4, then a clean transfer.
    load_valid = 1'b1; a = 8'hC3; b = 8'hC3;
    step();
    load_valid = 1'b0;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(sv0), 32'd0);
    chk("mid_rst_last", 32'(last0), 32'd0);
    chk("mid_rst_ready", 32'(lr0), 32'd1);
    model_reset();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b1; a = 8'h96; b = 8'h96;
    step();
    load_valid = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin
      step();
      n++;
    end
    chk("post_rst_len", 32'(n), 32'd8);

    // Random traffic against the beat-queue reference.
    for (int c = 0; c < 600; c++) begin
      load_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    load_valid = 1'b0;
    ser_ready = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
